// File: rtl/tdm_demux4.sv
// 4:1 TDM receiver: follows slot position from the frame-sync marker and hands a
// complete frame to channel outputs a..d at end of frame with a one-cycle valid pulse.
module tdm_demux4 #(
  parameter int WIDTH      = 1,
  parameter int MISS_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  input  logic             sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       s,
  output logic             valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state_q;
  logic [1:0]       s_q;
  logic [MW-1:0]    miss_q;
  logic [WIDTH-1:0] stg0_q, stg1_q, stg2_q;
  logic [WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic             valid_q, locked_q, sync_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      s_q        <= '0;
      miss_q     <= '0;
      stg0_q     <= '0;
      stg1_q     <= '0;
      stg2_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
      if (en) begin
        case (state_q)
          HUNT: begin
            if (sync) begin
              stg0_q   <= in;
              s_q      <= 2'd1;
              miss_q   <= '0;
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            if (sync && s_q != 2'd0) begin
              // Misaligned sync: drop the partial frame and restart at slot 0.
              sync_err_q <= 1'b1;
              stg0_q     <= in;
              s_q        <= 2'd1;
              miss_q     <= '0;
            end else if (s_q == 2'd0) begin
              if (sync) begin
                stg0_q <= in;
                s_q    <= 2'd1;
                miss_q <= '0;
              end else if (miss_q + 1'b1 == MISS_MAX) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
                s_q      <= 2'd0;
                miss_q   <= '0;
              end else begin
                stg0_q <= in;
                s_q    <= 2'd1;
                miss_q <= miss_q + 1'b1;
              end
            end else if (s_q == 2'd3) begin
              a_q     <= stg0_q;
              b_q     <= stg1_q;
              c_q     <= stg2_q;
              d_q     <= in;
              valid_q <= 1'b1;
              s_q     <= 2'd0;
            end else begin
              if (s_q == 2'd1) stg1_q <= in;
              else             stg2_q <= in;
              s_q <= s_q + 2'd1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign c        = c_q;
  assign d        = d_q;
  assign s        = s_q;
  assign valid    = valid_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule
